// File: rtl/result_writer_pkg.sv
// Shared definitions for the result writer: controller state encoding and
// default bus widths used by the top and its testbench.
package result_writer_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 512;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    ISSUE,
    WAIT_DONE,
    FINISH
  } state_t;

endpackage

// File: rtl/result_writer_fifo.sv
// Synchronous first-word-fall-through line buffer with full/empty flags.
// A push is accepted while full only when a pop happens in the same cycle.
module result_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/result_writer.sv
// Buffers DNN result lines and writes them one at a time to consecutive line
// addresses starting at a per-job base, with a single write outstanding.
module result_writer
  import result_writer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       num_results,
  input  logic              dnn_res_vld,
  input  logic [DATA_W-1:0] dnn_results,
  output logic              dnn_res_rdy,
  output logic              write_request_valid,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  input  logic              write_done,
  output logic              busy,
  output logic              done
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] base_lat;
  logic [15:0]       num_lat;
  logic [15:0]       accepted_cnt;
  logic [15:0]       written_cnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              push;
  logic              pop;
  logic              start_ok;
  logic              last_line;

  assign busy                = (state != IDLE);
  assign done                = (state == FINISH);
  assign write_request_valid = (state == ISSUE);
  assign dnn_res_rdy         = busy && !fifo_full && (accepted_cnt < num_lat);
  assign push                = dnn_res_vld && dnn_res_rdy;
  assign pop                 = (state == WAIT_DONE) && write_done;
  assign start_ok            = (state == IDLE) && start;
  assign last_line           = (written_cnt == num_lat - 16'd1);

  // written_cnt only moves on write_done, so the address holds through the write.
  assign address    = base_lat + ADDR_W'(written_cnt);
  assign write_data = fifo_empty ? '0 : fifo_head;

  result_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (dnn_results),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = (num_results == 16'd0) ? FINISH : RUN;
      RUN:       if (!fifo_empty) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_DONE;
      WAIT_DONE: if (write_done) state_nxt = last_line ? FINISH : RUN;
      FINISH:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_lat     <= '0;
      num_lat      <= '0;
      accepted_cnt <= '0;
      written_cnt  <= '0;
    end else if (start_ok) begin
      base_lat     <= base_addr;
      num_lat      <= num_results;
      accepted_cnt <= '0;
      written_cnt  <= '0;
    end else begin
      if (push) accepted_cnt <= accepted_cnt + 16'd1;
      if (pop)  written_cnt  <= written_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_result_writer.sv
// Directed bench for result_writer: write ordering, zero-length jobs,
// backpressure, job quota, address wrap and mid-job reset.
module tb_result_writer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [31:0]  base_addr;
  logic [15:0]  num_results;
  logic         dnn_res_vld;
  logic [511:0] dnn_results;
  logic         dnn_res_rdy;
  logic         write_request_valid;
  logic [31:0]  address;
  logic [511:0] write_data;
  logic         write_done;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_err = 0;

  result_writer dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .base_addr           (base_addr),
    .num_results         (num_results),
    .dnn_res_vld         (dnn_res_vld),
    .dnn_results         (dnn_results),
    .dnn_res_rdy         (dnn_res_rdy),
    .write_request_valid (write_request_valid),
    .address             (address),
    .write_data          (write_data),
    .write_done          (write_done),
    .busy                (busy),
    .done                (done)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] mk(input logic [31:0] v);
    return {16{v}};
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic start_job(input logic [31:0] b, input logic [15:0] n);
    start = 1'b1; base_addr = b; num_results = n;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (write_request_valid) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  // Waits for the next request, checks it, and completes it two cycles later.
  task automatic serve(input string tag, input logic [31:0] a, input logic [511:0] d);
    bit ok;
    wait_req(ok);
    chk({tag, " req"}, ok, 1'b1);
    chk({tag, " addr"}, address, a);
    chk({tag, " data"}, write_data, d);
    cyc();
    chk({tag, " req one cycle"}, write_request_valid, 1'b0);
    chk({tag, " addr held"}, address, a);
    cyc();
    write_done = 1'b1;
    cyc();
    write_done = 1'b0;
  endtask

  int  hs;
  bit  seen;
  logic [31:0]  req_a;
  logic [511:0] req_d;

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; num_results = '0;
    dnn_res_vld = 1'b0; dnn_results = '0; write_done = 1'b0;
    #2;
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst wrv", write_request_valid, 1'b0);
    chk("rst rdy", dnn_res_rdy, 1'b0);
    chk("rst addr", address, 32'h0);
    chk("rst data", write_data, 512'h0);
    cyc();
    rst = 1'b0;
    cyc();

    // Three lines from base 0x100; a stray write_done in RUN must not pop.
    start_job(32'h100, 16'd3);
    chk("j1 busy", busy, 1'b1);
    chk("j1 rdy", dnn_res_rdy, 1'b1);
    dnn_res_vld = 1'b1; dnn_results = mk(32'hA0000000);
    cyc();
    dnn_res_vld = 1'b0; write_done = 1'b1;
    chk("j1 no req yet", write_request_valid, 1'b0);
    cyc();
    write_done = 1'b0;
    chk("j1 latency req", write_request_valid, 1'b1);
    chk("j1 l0 addr", address, 32'h100);
    chk("j1 l0 data", write_data, mk(32'hA0000000));
    cyc();
    chk("j1 l0 req one cycle", write_request_valid, 1'b0);
    dnn_res_vld = 1'b1; dnn_results = mk(32'hA0000001);
    cyc();
    dnn_results = mk(32'hA0000002); write_done = 1'b1;
    cyc();
    dnn_res_vld = 1'b0; write_done = 1'b0;
    serve("j1 l1", 32'h101, mk(32'hA0000001));
    serve("j1 l2", 32'h102, mk(32'hA0000002));
    chk("j1 done", done, 1'b1);
    chk("j1 rdy at quota", dnn_res_rdy, 1'b0);
    cyc();
    chk("j1 done pulse", done, 1'b0);
    chk("j1 idle", busy, 1'b0);

    // Zero-length job: start cycle, then done in the following cycle.
    start = 1'b1; base_addr = 32'h0; num_results = 16'd0;
    #1;
    chk("n0 done not in start cycle", done, 1'b0);
    cyc();
    start = 1'b0;
    chk("n0 done", done, 1'b1);
    chk("n0 rdy", dnn_res_rdy, 1'b0);
    chk("n0 wrv", write_request_valid, 1'b0);
    cyc();
    chk("n0 done pulse", done, 1'b0);
    chk("n0 idle", busy, 1'b0);
    chk("n0 wrv after", write_request_valid, 1'b0);

    // Backpressure: eight lines offered, write_done withheld, FIFO holds four.
    start_job(32'h200, 16'd8);
    hs = 0; seen = 1'b0; req_a = '0; req_d = '0;
    dnn_res_vld = 1'b1;
    for (int k = 0; k < 12; k++) begin
      dnn_results = mk(32'hB0000000 + 32'(hs));
      if (write_request_valid && !seen) begin
        seen = 1'b1; req_a = address; req_d = write_data;
      end
      if (dnn_res_rdy) hs++;
      cyc();
    end
    chk("bp accepted", hs, 4);
    chk("bp rdy low", dnn_res_rdy, 1'b0);
    chk("bp req seen", seen, 1'b1);
    chk("bp req addr", req_a, 32'h200);
    chk("bp req data", req_d, mk(32'hB0000000));
    write_done = 1'b1;
    cyc();
    write_done = 1'b0;
    chk("bp rdy after pop", dnn_res_rdy, 1'b1);
    dnn_res_vld = 1'b0;
    do_reset();

    // Quota: two lines requested while valid is held for five cycles.
    start_job(32'h300, 16'd2);
    hs = 0; seen = 1'b0; req_a = '0; req_d = '0;
    dnn_res_vld = 1'b1;
    for (int k = 0; k < 5; k++) begin
      dnn_results = mk(32'hC0000040 + 32'(k));
      if (write_request_valid && !seen) begin
        seen = 1'b1; req_a = address; req_d = write_data;
      end
      if (dnn_res_rdy) hs++;
      cyc();
    end
    dnn_res_vld = 1'b0;
    chk("q handshakes", hs, 2);
    chk("q req seen", seen, 1'b1);
    chk("q l0 addr", req_a, 32'h300);
    chk("q l0 data", req_d, mk(32'hC0000040));
    write_done = 1'b1;
    cyc();
    write_done = 1'b0;
    serve("q l1", 32'h301, mk(32'hC0000041));
    chk("q done", done, 1'b1);
    cyc();

    // Address wrap across 2^32.
    start_job(32'hFFFFFFFF, 16'd2);
    dnn_res_vld = 1'b1; dnn_results = mk(32'hD0000000);
    cyc();
    dnn_results = mk(32'hD0000001);
    cyc();
    dnn_res_vld = 1'b0;
    serve("wrap l0", 32'hFFFFFFFF, mk(32'hD0000000));
    serve("wrap l1", 32'h00000000, mk(32'hD0000001));
    chk("wrap done", done, 1'b1);
    cyc();

    // Reset while waiting on a write, then a fresh one-line job.
    start_job(32'h400, 16'd2);
    dnn_res_vld = 1'b1; dnn_results = mk(32'hE0000060);
    cyc();
    dnn_results = mk(32'hE0000061);
    cyc();
    dnn_res_vld = 1'b0;
    wait_req(seen);
    chk("mr req", seen, 1'b1);
    cyc();
    rst = 1'b1;
    cyc();
    chk("mr busy", busy, 1'b0);
    chk("mr done", done, 1'b0);
    chk("mr wrv", write_request_valid, 1'b0);
    chk("mr rdy", dnn_res_rdy, 1'b0);
    chk("mr addr", address, 32'h0);
    chk("mr data", write_data, 512'h0);
    rst = 1'b0;
    cyc();
    cyc();
    chk("mr no req before start", write_request_valid, 1'b0);
    start_job(32'h500, 16'd1);
    dnn_res_vld = 1'b1; dnn_results = mk(32'hE0000070);
    cyc();
    dnn_res_vld = 1'b0;
    serve("mr new", 32'h500, mk(32'hE0000070));
    chk("mr new done", done, 1'b1);
    cyc();
    chk("mr idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
